// File: rtl/xg_pon_pkg.sv
// Shared XG-PON TX definitions: framing constants, framer state encoding
// and the AXI-Stream beat bundle carried through the output register.
package xg_pon_pkg;

  localparam logic [31:0] XGPON_PREAMBLE        = 32'h05560556;
  localparam logic [31:0] XGPON_DELIMITER       = 32'hb2c50fa1;
  localparam logic [31:0] XGPON_MAX_BURST_WORDS = 32'h10f;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DELIM    = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_GUARD    = 3'd5
  } framer_state_e;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } axis_beat_t;

  // Header words always carry full byte enables and never end the burst.
  function automatic axis_beat_t header_beat(input logic [31:0] word, input logic first);
    axis_beat_t b;
    b.user = first;
    b.last = 1'b0;
    b.keep = 4'hF;
    b.data = word;
    return b;
  endfunction

endpackage

// File: rtl/xg_pon_burst_framer_axis_out_reg.sv
// Single-stage AXI-Stream output register. The owner computes load_en as
// (!q_valid || downstream ready); when load_en is low every output holds,
// which keeps the beat stable across a stall.
module axis_out_reg
  import xg_pon_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       load_en,
  input  logic       d_valid,
  input  axis_beat_t d_beat,
  output logic       q_valid,
  output axis_beat_t q_beat
);

  // Capture the next beat (or a bubble) whenever the stage is free to move.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      q_valid <= 1'b0;
      q_beat  <= '0;
    end else if (load_en) begin
      q_valid <= d_valid;
      q_beat  <= d_beat;
    end
  end

endmodule

// File: rtl/xg_pon_burst_framer.sv
// Upstream burst framer: prepends PREAMBLE_LEN preamble words and one
// delimiter to each payload burst, caps payload at MAX_PAYLOAD words
// (dropping the rest of an over-long burst), then idles for GUARD_LEN
// cycles after the final output handshake.
//
// Handshake: a word moves on either AXI-Stream side only in a cycle where
// TVALID and TREADY are both high at the rising edge; TVALID never depends
// on TREADY, and a valid output word holds all its fields until accepted.
module xg_pon_burst_framer
  import xg_pon_pkg::*;
#(
  parameter logic [31:0] PREAMBLE_WORD  = XGPON_PREAMBLE,
  parameter int unsigned PREAMBLE_LEN   = 8,
  parameter logic [31:0] DELIMITER_WORD = XGPON_DELIMITER,
  parameter int unsigned MAX_PAYLOAD    = XGPON_MAX_BURST_WORDS,
  parameter int unsigned GUARD_LEN      = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] axis_TDATA_in,
  input  logic        axis_TVALID_in,
  input  logic [3:0]  axis_TKEEP_in,
  input  logic        axis_TLAST_in,
  input  logic        axis_TUSER_in,
  output logic        axis_TREADY_out,
  output logic [31:0] axis_TDATA_out,
  output logic        axis_TVALID_out,
  output logic [3:0]  axis_TKEEP_out,
  output logic        axis_TLAST_out,
  output logic        axis_TUSER_out,
  input  logic        axis_TREADY_in,
  output logic        busy_out,
  output logic        trunc_err_out
);

  localparam logic [7:0]  HDR_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [15:0] PAY_LAST = 16'(MAX_PAYLOAD - 1);
  localparam logic [15:0] GUARD_W  = 16'(GUARD_LEN);

  framer_state_e state, state_nxt;
  logic [7:0]    hdr_cnt, hdr_cnt_nxt;
  logic [15:0]   pay_cnt, pay_cnt_nxt;
  logic [15:0]   guard_cnt, guard_cnt_nxt;
  logic          trunc_q, trunc_nxt;

  logic          load_en;
  logic          in_hs;
  logic          ld_valid;
  axis_beat_t    ld_beat;
  logic          out_valid;
  axis_beat_t    out_beat;

  // Next-state, counter and output-register load decisions.
  always_comb begin
    state_nxt     = state;
    hdr_cnt_nxt   = hdr_cnt;
    pay_cnt_nxt   = pay_cnt;
    guard_cnt_nxt = guard_cnt;
    trunc_nxt     = 1'b0;
    ld_valid      = 1'b0;
    ld_beat       = '0;
    load_en       = !out_valid || axis_TREADY_in;

    case (state)
      ST_PAYLOAD: axis_TREADY_out = load_en;
      ST_DRAIN:   axis_TREADY_out = 1'b1;
      default:    axis_TREADY_out = 1'b0;
    endcase
    in_hs = axis_TVALID_in && axis_TREADY_out;

    case (state)
      ST_IDLE: begin
        // The first preamble word is loaded in the same cycle the pending
        // input is seen, so it appears on the output one cycle later.
        if (axis_TVALID_in && load_en) begin
          ld_valid    = 1'b1;
          ld_beat     = header_beat(PREAMBLE_WORD, 1'b1);
          hdr_cnt_nxt = 8'd1;
          pay_cnt_nxt = 16'd0;
          state_nxt   = (PREAMBLE_LEN == 1) ? ST_DELIM : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (load_en) begin
          ld_valid    = 1'b1;
          ld_beat     = header_beat(PREAMBLE_WORD, 1'b0);
          hdr_cnt_nxt = hdr_cnt + 8'd1;
          if (hdr_cnt == HDR_LAST) state_nxt = ST_DELIM;
        end
      end
      ST_DELIM: begin
        if (load_en) begin
          ld_valid  = 1'b1;
          ld_beat   = header_beat(DELIMITER_WORD, 1'b0);
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (in_hs) begin
          ld_valid     = 1'b1;
          ld_beat.data = axis_TDATA_in;
          ld_beat.keep = axis_TKEEP_in;
          ld_beat.user = axis_TUSER_in;
          ld_beat.last = axis_TLAST_in || (pay_cnt == PAY_LAST);
          pay_cnt_nxt  = pay_cnt + 16'd1;
          if (axis_TLAST_in) begin
            state_nxt     = ST_GUARD;
            guard_cnt_nxt = 16'd0;
          end else if (pay_cnt == PAY_LAST) begin
            trunc_nxt = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (axis_TVALID_in && axis_TLAST_in) begin
          state_nxt     = ST_GUARD;
          guard_cnt_nxt = 16'd0;
        end
      end
      ST_GUARD: begin
        // Counting starts in the cycle the final word handshakes
        // (load_en high means the register is empty or emptying).
        if (load_en) begin
          if (guard_cnt == GUARD_W) state_nxt = ST_IDLE;
          else                      guard_cnt_nxt = guard_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state     <= ST_IDLE;
      hdr_cnt   <= 8'd0;
      pay_cnt   <= 16'd0;
      guard_cnt <= 16'd0;
      trunc_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hdr_cnt   <= hdr_cnt_nxt;
      pay_cnt   <= pay_cnt_nxt;
      guard_cnt <= guard_cnt_nxt;
      trunc_q   <= trunc_nxt;
    end
  end

  axis_out_reg u_out_reg (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load_en  (load_en),
    .d_valid  (ld_valid),
    .d_beat   (ld_beat),
    .q_valid  (out_valid),
    .q_beat   (out_beat)
  );

  assign axis_TVALID_out = out_valid;
  assign axis_TDATA_out  = out_beat.data;
  assign axis_TKEEP_out  = out_beat.keep;
  assign axis_TLAST_out  = out_beat.last;
  assign axis_TUSER_out  = out_beat.user;
  assign busy_out        = (state != ST_IDLE);
  assign trunc_err_out   = trunc_q;

endmodule
